// File: rtl/cr16_datapath.sv
// cr16_datapath: CompactRISC16 execution datapath.
// 16 x 16-bit register file, immediate/register operand mux, combinational
// ALU and a registered {N,Z,F,L,C} flag word.
// Optional build macro: CR16_R0_ZERO_EN hardwires r0 to zero (reads 0, writes ignored).
module cr16_datapath #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 16,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  I_CLK,
    input  logic                  I_NRESET,
    input  logic                  I_ENABLE,
    input  logic [NUM_REGS-1:0]   I_REG_ENABLE,
    input  logic [3:0]            I_OPCODE,
    input  logic [SEL_WIDTH-1:0]  I_READ_PORT_A_SEL,
    input  logic [SEL_WIDTH-1:0]  I_READ_PORT_B_SEL,
    input  logic [DATA_WIDTH-1:0] I_IMMEDIATE,
    input  logic                  I_IMM_SEL,
    output logic [DATA_WIDTH-1:0] O_WRITE_PORT,
    output logic [4:0]            O_FLAGS
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDC = 4'h1,
        OP_SUB  = 4'h2,
        OP_SUBC = 4'h3,
        OP_CMP  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_NOT  = 4'h8,
        OP_MOV  = 4'h9,
        OP_LSH  = 4'hA,
        OP_ARSH = 4'hB,
        OP_LUI  = 4'hC
    } opcode_e;

    localparam int MSB  = DATA_WIDTH - 1;
    localparam int SHW  = $clog2(DATA_WIDTH);
    localparam int HALF = DATA_WIDTH / 2;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [4:0]            flags_q, flags_d;

    logic [DATA_WIDTH-1:0] op_a, op_b, result;
    logic [DATA_WIDTH:0]   ext;          // sum/difference with carry/borrow in the top bit
    logic [SHW-1:0]        shamt, shamt_neg;
    logic                  cin_eff, lt_u, lt_s, ovf;
    logic [4:0]            alu_flags;
    logic                  flag_wr;

    // Operand selection: register reads are combinational and see pre-edge contents.
    always_comb begin
        op_a = regs_q[I_READ_PORT_A_SEL];
        op_b = I_IMM_SEL ? I_IMMEDIATE : regs_q[I_READ_PORT_B_SEL];
    end

    // ALU: result for every opcode plus the candidate flag word for arith/CMP.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        result    = '0;
        ext       = '0;
        ovf       = 1'b0;
        alu_flags = flags_q;
        flag_wr   = 1'b0;
        cin_eff   = flags_q[0] & ((I_OPCODE == OP_ADDC) || (I_OPCODE == OP_SUBC));
        lt_u      = op_a < op_b;
        lt_s      = $signed(op_a) < $signed(op_b);
        shamt     = op_b[SHW-1:0];
        shamt_neg = -shamt;
        case (I_OPCODE)
            OP_ADD, OP_ADDC: begin
                ext       = {1'b0, op_a} + {1'b0, op_b} + {{DATA_WIDTH{1'b0}}, cin_eff};
                result    = ext[MSB:0];
                ovf       = (op_a[MSB] == op_b[MSB]) && (result[MSB] != op_a[MSB]);
                alu_flags = {result[MSB], ~|result, ovf, lt_u, ext[DATA_WIDTH]};
                flag_wr   = 1'b1;
            end
            OP_SUB, OP_SUBC, OP_CMP: begin
                // CMP keeps A on the write port but takes its flags from A-B.
                ext       = {1'b0, op_a} - {1'b0, op_b} - {{DATA_WIDTH{1'b0}}, cin_eff};
                ovf       = (op_a[MSB] != op_b[MSB]) && (ext[MSB] != op_a[MSB]);
                result    = (I_OPCODE == OP_CMP) ? op_a : ext[MSB:0];
                alu_flags = {lt_s, ~|ext[MSB:0], ovf, lt_u, ext[DATA_WIDTH]};
                flag_wr   = 1'b1;
            end
            OP_AND:  result = op_a & op_b;
            OP_OR:   result = op_a | op_b;
            OP_XOR:  result = op_a ^ op_b;
            OP_NOT:  result = ~op_a;
            OP_MOV:  result = op_b;
            // Negative B (sign bit set) shifts right by the two's-complement magnitude.
            OP_LSH:  result = op_b[MSB] ? (op_a >> shamt_neg) : (op_a << shamt);
            OP_ARSH: result = $unsigned($signed(op_a) >>> shamt);
            OP_LUI:  result = {op_b[HALF-1:0], {HALF{1'b0}}};
            default: result = '0;
        endcase
    end

    // Next-state: enabled registers load the ALU result; flags load on arith/CMP only.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = (I_ENABLE && I_REG_ENABLE[i]) ? result : regs_q[i];
        end
`ifdef CR16_R0_ZERO_EN
        regs_d[0] = '0;
`endif
        flags_d = (I_ENABLE && flag_wr) ? alu_flags : flags_q;
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        // NOTE: the register file is built from flops, not a RAM macro, so it takes the async clear like any other state.
        if (!I_NRESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            flags_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values and same-cycle reads see the old data.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            flags_q <= flags_d;
        end
    end

    assign O_WRITE_PORT = result;
    assign O_FLAGS      = flags_q;

endmodule

// File: tb/tb_cr16_datapath.sv
// tb_cr16_datapath: scoreboard bench for cr16_datapath.
// A driver issues one operation per cycle and pushes the expected write-port
// value and flag word; a monitor pops and compares on the falling edge.
module tb_cr16_datapath;

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h2, CMP = 4'h4, MOV = 4'h9,
                           LSH = 4'hA, ARSH = 4'hB;

    logic        I_CLK = 1'b0;
    logic        I_NRESET = 1'b1;
    logic        I_ENABLE = 1'b0;
    logic [15:0] I_REG_ENABLE = '0;
    logic [3:0]  I_OPCODE = '0;
    logic [3:0]  I_READ_PORT_A_SEL = '0;
    logic [3:0]  I_READ_PORT_B_SEL = '0;
    logic [15:0] I_IMMEDIATE = '0;
    logic        I_IMM_SEL = 1'b0;
    logic [15:0] O_WRITE_PORT;
    logic [4:0]  O_FLAGS;

    cr16_datapath dut (
        .I_CLK             (I_CLK),
        .I_NRESET          (I_NRESET),
        .I_ENABLE          (I_ENABLE),
        .I_REG_ENABLE      (I_REG_ENABLE),
        .I_OPCODE          (I_OPCODE),
        .I_READ_PORT_A_SEL (I_READ_PORT_A_SEL),
        .I_READ_PORT_B_SEL (I_READ_PORT_B_SEL),
        .I_IMMEDIATE       (I_IMMEDIATE),
        .I_IMM_SEL         (I_IMM_SEL),
        .O_WRITE_PORT      (O_WRITE_PORT),
        .O_FLAGS           (O_FLAGS)
    );

    always #5 I_CLK = ~I_CLK;

    typedef struct {
        string       name;
        logic [15:0] wp;
        logic [4:0]  fl;
    } exp_t;

    exp_t       exp_q[$];
    int         passed = 0;
    int         total  = 0;
    int         model_regs[16];
    logic [4:0] model_flags;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic bit ovf16(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    // Reference ALU from the arithmetic definitions, on plain integers.
    function automatic void alu_model(input int op, input int a, input int b, input int c,
                                      output int res, output logic [4:0] fl, output bit upd);
        int sa, sb, full, dres, amt, cc;
        sa   = (a >= 32768) ? a - 65536 : a;
        sb   = (b >= 32768) ? b - 65536 : b;
        amt  = b % 16;
        cc   = 0;
        res  = 0;
        fl   = model_flags;
        upd  = 1'b0;
        case (op)
            0, 1: begin
                if (op == 1) cc = c;
                full = a + b + cc;
                res  = full % 65536;
                fl   = {res >= 32768, res == 0, ovf16(sa + sb + cc), a < b, full > 65535};
                upd  = 1'b1;
            end
            2, 3: begin
                if (op == 3) cc = c;
                full = a - b - cc;
                res  = (full + 65536) % 65536;
                fl   = {sa < sb, res == 0, ovf16(sa - sb - cc), a < b, full < 0};
                upd  = 1'b1;
            end
            4: begin
                full = a - b;
                dres = (full + 65536) % 65536;
                res  = a;
                fl   = {sa < sb, dres == 0, ovf16(sa - sb), a < b, full < 0};
                upd  = 1'b1;
            end
            5:  res = a & b;
            6:  res = a | b;
            7:  res = a ^ b;
            8:  res = (~a) & 65535;
            9:  res = b;
            10: res = (b >= 32768) ? (a >> ((16 - amt) % 16)) : ((a << amt) & 65535);
            11: res = (sa >>> amt) & 65535;
            12: res = (b % 256) * 256;
            default: res = 0;
        endcase
    endfunction

    // Predict the current cycle's outputs, queue them, then apply the coming edge to the model.
    task automatic predict(input string name);
        exp_t       e;
        int         a, b, res;
        logic [4:0] fl;
        bit         upd;
        a = model_regs[I_READ_PORT_A_SEL];
        b = I_IMM_SEL ? int'(I_IMMEDIATE) : model_regs[I_READ_PORT_B_SEL];
        alu_model(int'(I_OPCODE), a, b, int'(model_flags[0]), res, fl, upd);
        e.name = name;
        e.wp   = res[15:0];
        e.fl   = model_flags;
        exp_q.push_back(e);
        if (I_ENABLE && I_NRESET) begin
            for (int i = 0; i < 16; i++) begin
                if (I_REG_ENABLE[i]) model_regs[i] = res;
            end
`ifdef CR16_R0_ZERO_EN
            model_regs[0] = 0;
`endif
            if (upd) model_flags = fl;
        end
    endtask

    task automatic issue(input string name, input logic en, input logic [15:0] ren,
                         input logic [3:0] op, input logic [3:0] asel, input logic [3:0] bsel,
                         input logic [15:0] imm, input logic isel);
        @(posedge I_CLK);
        #1;
        I_ENABLE          = en;
        I_REG_ENABLE      = ren;
        I_OPCODE          = op;
        I_READ_PORT_A_SEL = asel;
        I_READ_PORT_B_SEL = bsel;
        I_IMMEDIATE       = imm;
        I_IMM_SEL         = isel;
        predict(name);
    endtask

    // Replace the newest model prediction with a hand-derived constant.
    task automatic fix_wp(input logic [15:0] v);
        exp_t e;
        e    = exp_q.pop_back();
        e.wp = v;
        exp_q.push_back(e);
    endtask

    task automatic fix_fl(input logic [4:0] v);
        exp_t e;
        e    = exp_q.pop_back();
        e.fl = v;
        exp_q.push_back(e);
    endtask

    // Assert reset between clock edges and check r15/flags clear before any edge.
    task automatic reset_mid(input string name);
        @(posedge I_CLK);
        #2;
        I_NRESET = 1'b0;
        for (int i = 0; i < 16; i++) model_regs[i] = 0;
        model_flags       = '0;
        I_ENABLE          = 1'b0;
        I_REG_ENABLE      = '0;
        I_OPCODE          = MOV;
        I_READ_PORT_B_SEL = 4'd15;
        I_IMM_SEL         = 1'b0;
        predict(name);
    endtask

    task automatic release_rst();
        @(posedge I_CLK);
        #1;
        I_ENABLE = 1'b0;
        I_NRESET = 1'b1;
    endtask

    task automatic random_op();
        logic [15:0] ren, imm;
        case ($urandom_range(0, 3))
            0:       ren = '0;
            1:       ren = 16'h1 << $urandom_range(0, 15);
            2:       ren = 16'($urandom);
            default: ren = 16'hFFFF;
        endcase
        case ($urandom_range(0, 4))
            0:       imm = 16'h0000;
            1:       imm = 16'hFFFF;
            2:       imm = 16'h8000;
            3:       imm = 16'h7FFF;
            default: imm = 16'($urandom);
        endcase
        issue("rand", $urandom_range(0, 7) != 0, ren, 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), imm, 1'($urandom));
    endtask

    // Monitor: compare the oldest prediction against the DUT away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge I_CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, "_wp"}, O_WRITE_PORT, e.wp);
                check({e.name, "_flags"}, {11'b0, O_FLAGS}, {11'b0, e.fl});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) model_regs[i] = 0;
        model_flags = '0;
        #1 I_NRESET = 1'b0;

        reset_mid("rst_init");
        release_rst();

        // Immediate load through a zero register.
        issue("imm_r0", 1'b1, 16'h0001, ADD, 4'd3, 4'd0, 16'h0001, 1'b1);
        fix_wp(16'h0001);
        issue("imm_r1", 1'b1, 16'h0002, ADD, 4'd3, 4'd0, 16'h0001, 1'b1);
        fix_wp(16'h0001);

        // Fibonacci chain r2..r15.
        for (int k = 2; k < 16; k++) begin
            issue("fib", 1'b1, 16'h1 << k, ADD, 4'(k - 2), 4'(k - 1), 16'h0000, 1'b0);
        end
        issue("rd_r15", 1'b0, 16'h0000, MOV, 4'd0, 4'd15, 16'h0000, 1'b0);
`ifndef CR16_R0_ZERO_EN
        fix_wp(16'd987);
`endif

        // Flag cases.
        issue("ld_7fff", 1'b1, 16'h0002, MOV, 4'd0, 4'd0, 16'h7FFF, 1'b1);
        issue("add_ovf", 1'b1, 16'h0000, ADD, 4'd1, 4'd0, 16'h0001, 1'b1);
        fix_wp(16'h8000);
        issue("ld_5", 1'b1, 16'h0004, MOV, 4'd0, 4'd0, 16'h0005, 1'b1);
        fix_fl(5'b10100);
        issue("sub", 1'b1, 16'h0000, SUB, 4'd2, 4'd0, 16'h0007, 1'b1);
        fix_wp(16'hFFFE);
        issue("ld_3", 1'b1, 16'h0008, MOV, 4'd0, 4'd0, 16'h0003, 1'b1);
        fix_fl(5'b10011);
        issue("cmp", 1'b1, 16'h0000, CMP, 4'd3, 4'd0, 16'h0003, 1'b1);
        fix_wp(16'h0003);

        // Global enable low: nothing may change.
        issue("gate", 1'b0, 16'hFFFF, ADD, 4'd3, 4'd0, 16'h1234, 1'b1);
        fix_wp(16'h1237);
        fix_fl(5'b01000);
        for (int i = 0; i < 16; i++) begin
            issue("gate_rd", 1'b0, 16'h0000, MOV, 4'd0, 4'(i), 16'h0000, 1'b0);
            if (i == 0) fix_fl(5'b01000);
        end

        // Shifts.
        issue("ld_1", 1'b1, 16'h0010, MOV, 4'd0, 4'd0, 16'h0001, 1'b1);
        issue("lsh_l", 1'b1, 16'h0000, LSH, 4'd4, 4'd0, 16'h0004, 1'b1);
        fix_wp(16'h0010);
        issue("ld_100", 1'b1, 16'h0020, MOV, 4'd0, 4'd0, 16'h0100, 1'b1);
        issue("lsh_r", 1'b1, 16'h0000, LSH, 4'd5, 4'd0, 16'hFFFC, 1'b1);
        fix_wp(16'h0010);
        issue("ld_8000", 1'b1, 16'h0040, MOV, 4'd0, 4'd0, 16'h8000, 1'b1);
        issue("arsh", 1'b1, 16'h0000, ARSH, 4'd6, 4'd0, 16'h0003, 1'b1);
        fix_wp(16'hF000);

        // Reset mid-operation, writes attempted while it is held.
        reset_mid("rst_mid");
        fix_wp(16'h0000);
        fix_fl(5'b00000);
        for (int i = 0; i < 4; i++) begin
            issue("rst_hold", 1'b1, 16'hFFFF, ADD, 4'(i), 4'(15 - i), 16'h5A5A, 1'b1);
            issue("rst_rd", 1'b1, 16'hFFFF, MOV, 4'd0, 4'(i + 8), 16'h0000, 1'b0);
        end
        release_rst();
        for (int i = 0; i < 16; i++) begin
            issue("post_rst_rd", 1'b0, 16'h0000, MOV, 4'd0, 4'(i), 16'h0000, 1'b0);
        end

        // Randomised traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            random_op();
        end

        @(posedge I_CLK);
        #1 I_ENABLE = 1'b0;
        repeat (2) @(negedge I_CLK);
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
